mmc1_serial_writer: RTL and testbench

MMC1_SERIAL_WRITER -- requirements
Module: mmc1_serial_writer

---
 rtl/mmc1_serial_writer_pkg.sv | 30 +++
 rtl/mmc1_serial_writer_cpu_frame_detect.sv | 21 ++
 rtl/mmc1_serial_writer.sv | 129 ++++++++++++
 tb/tb_mmc1_serial_writer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_serial_writer_pkg.sv
// rtl/mmc1_serial_writer_pkg.sv - shared types and constants for the MMC1 serial writer
package mmc1_serial_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WR_HIGH,
        ST_WR_GAP
    } state_e;

    localparam logic [1:0] REG_CONTROL = 2'd0;
    localparam logic [1:0] REG_CHR0    = 2'd1;
    localparam logic [1:0] REG_CHR1    = 2'd2;
    localparam logic [1:0] REG_PRG     = 2'd3;

    localparam logic [15:0] LOAD_BASE        = 16'h8000;
    localparam logic [15:0] REG_STRIDE       = 16'h2000;
    localparam logic [7:0]  SHIFT_RESET_DATA = 8'h80;
    localparam int          LOAD_BITS        = 5;
    localparam logic [2:0]  LAST_BIT_IDX     = 3'(LOAD_BITS - 1);

    function automatic logic [15:0] load_address(input logic [1:0] reg_idx);
        return LOAD_BASE + REG_STRIDE * {14'd0, reg_idx};
    endfunction

    function automatic logic [7:0] load_data(input logic [4:0] value, input logic [2:0] idx);
        return {7'd0, value[idx]};
    endfunction

endpackage

// File: rtl/mmc1_serial_writer_cpu_frame_detect.sv
// rtl/mmc1_serial_writer_cpu_frame_detect.sv - rising-edge detector for the sampled CPU clock level
module cpu_frame_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_clk_i,
    output logic cpu_frame_o
);

    logic cpu_clk_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_clk_last_q <= 1'b0;
        end else begin
            cpu_clk_last_q <= cpu_clk_i;
        end
    end

    assign cpu_frame_o = ~cpu_clk_last_q & cpu_clk_i;

endmodule

// File: rtl/mmc1_serial_writer.sv
// rtl/mmc1_serial_writer.sv - serialises 5-bit MMC1 register loads into CPU-bus write strobes
module mmc1_serial_writer
    import mmc1_serial_writer_pkg::*;
(
    input  logic        cart_clk_in,
    input  logic        reset_in,
    input  logic        cpu_clk_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [1:0]  req_reg_in,
    input  logic [4:0]  req_data_in,
    input  logic        req_reset_in,
    output logic        prg_write_out,
    output logic [15:0] prg_address_out,
    output logic [7:0]  prg_data_out,
    output logic        done_out
);

    state_e      state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  reg_q, reg_d;
    logic [4:0]  data_q, data_d;
    logic        rst_req_q, rst_req_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        cpu_frame;

    cpu_frame_detect u_frame (
        .clk_i       (cart_clk_in),
        .rst_i       (reset_in),
        .cpu_clk_i   (cpu_clk_in),
        .cpu_frame_o (cpu_frame)
    );

    always_ff @(posedge cart_clk_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            reg_q     <= 2'd0;
            data_q    <= 5'd0;
            rst_req_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            rst_req_q <= rst_req_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    // Outputs are registered, so every strobe edge lands one cart_clk after its cpu_frame.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        reg_d     = reg_q;
        data_d    = data_q;
        rst_req_d = rst_req_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    reg_d     = req_reg_in;
                    data_d    = req_data_in;
                    rst_req_d = req_reset_in;
                    bit_idx_d = 3'd0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                if (cpu_frame) begin
                    write_d = 1'b1;
                    if (rst_req_q) begin
                        addr_d  = LOAD_BASE;
                        wdata_d = SHIFT_RESET_DATA;
                    end else begin
                        addr_d  = load_address(reg_q);
                        wdata_d = load_data(data_q, bit_idx_q);
                    end
                    state_d = ST_WR_HIGH;
                end
            end
            ST_WR_HIGH: begin
                if (cpu_frame) begin
                    write_d = 1'b0;
                    if (rst_req_q || bit_idx_q == LAST_BIT_IDX) begin
                        done_d  = 1'b1;
                        addr_d  = 16'h0000;
                        wdata_d = 8'h00;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WR_GAP;
                    end
                end
            end
            ST_WR_GAP: begin
                if (cpu_frame) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    write_d   = 1'b1;
                    wdata_d   = load_data(data_q, bit_idx_q + 3'd1);
                    state_d   = ST_WR_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_out   = (state_q == ST_IDLE);
    assign prg_write_out   = write_q;
    assign prg_address_out = addr_q;
    assign prg_data_out    = wdata_q;
    assign done_out        = done_q;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// tb/tb_mmc1_serial_writer.sv - directed bench for mmc1_serial_writer with an MMC1 shift-register model
module tb_mmc1_serial_writer;

    logic        cart_clk_in = 1'b0;
    logic        reset_in;
    logic        cpu_clk_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [1:0]  req_reg_in;
    logic [4:0]  req_data_in;
    logic        req_reset_in;
    logic        prg_write_out;
    logic [15:0] prg_address_out;
    logic [7:0]  prg_data_out;
    logic        done_out;

    int n_checks = 0;
    int n_fail   = 0;
    int half_ratio = 6;

    mmc1_serial_writer dut (
        .cart_clk_in     (cart_clk_in),
        .reset_in        (reset_in),
        .cpu_clk_in      (cpu_clk_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_reg_in      (req_reg_in),
        .req_data_in     (req_data_in),
        .req_reset_in    (req_reset_in),
        .prg_write_out   (prg_write_out),
        .prg_address_out (prg_address_out),
        .prg_data_out    (prg_data_out),
        .done_out        (done_out)
    );

    always #5 cart_clk_in = ~cart_clk_in;

    initial begin
        int cnt;
        cnt = 0;
        cpu_clk_in = 1'b0;
        forever begin
            @(negedge cart_clk_in);
            cnt++;
            if (cnt >= half_ratio) begin
                cnt = 0;
                cpu_clk_in = ~cpu_clk_in;
            end
        end
    end

    // Reference count of CPU rising edges as seen on cart_clk.
    logic cpu_last_tb = 1'b0;
    int   frames_total = 0;
    always @(posedge cart_clk_in) begin
        if (cpu_clk_in && !cpu_last_tb) frames_total <= frames_total + 1;
        cpu_last_tb <= reset_in ? 1'b0 : cpu_clk_in;
    end

    // Bus monitor plus MMC1 mapper model.
    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          gaps[$];
    int          highs[$];
    int          cyc = 0, last_fall = -1000, hi_start = 0;
    int          done_cnt = 0, done_frame = 0, first_frame = 0;
    bit          tx_first = 1'b1;
    logic        prev_w = 1'b0;
    logic [4:0]  map_sh = 5'd0;
    int          map_cnt = 0;
    logic [4:0]  map_reg[4] = '{default: 5'd0};

    always begin
        @(posedge cart_clk_in);
        #2;
        cyc++;
        if (reset_in) tx_first = 1'b1;
        if (prg_write_out && !prev_w) begin
            wr_addr.push_back(prg_address_out);
            wr_data.push_back(prg_data_out);
            gaps.push_back(cyc - last_fall);
            hi_start = cyc;
            if (tx_first) begin
                first_frame = frames_total;
                tx_first = 1'b0;
            end
            if (prg_data_out[7]) begin
                map_sh = 5'd0;
                map_cnt = 0;
            end else begin
                map_sh = map_sh | (5'(prg_data_out[0]) << map_cnt);
                map_cnt++;
                if (map_cnt == 5) begin
                    map_reg[prg_address_out[14:13]] = map_sh;
                    map_sh = 5'd0;
                    map_cnt = 0;
                end
            end
        end
        if (!prg_write_out && prev_w) begin
            highs.push_back(cyc - hi_start);
            last_fall = cyc;
        end
        if (done_out) begin
            done_cnt++;
            done_frame = frames_total;
            tx_first = 1'b1;
        end
        prev_w = prg_write_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] r, input logic [4:0] d, input logic rs, input bit keep);
        int n;
        n = 0;
        @(negedge cart_clk_in);
        req_reg_in = r;
        req_data_in = d;
        req_reset_in = rs;
        req_valid_in = 1'b1;
        while (!req_ready_out && n < 2000) begin
            @(negedge cart_clk_in);
            n++;
        end
        chk("accept_timeout", 32'(req_ready_out), 32'd1);
        @(negedge cart_clk_in);
        if (!keep) req_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge cart_clk_in);
            n++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, hbase, gbase, d0, accept_frame, n, min_gap;
        logic [4:0] v;
        reset_in = 1'b1;
        req_valid_in = 1'b0;
        req_reg_in = 2'd0;
        req_data_in = 5'd0;
        req_reset_in = 1'b0;

        repeat (4) @(negedge cart_clk_in);
        chk("rst_ready", 32'(req_ready_out), 32'd1);
        chk("rst_write", 32'(prg_write_out), 32'd0);
        chk("rst_addr", 32'(prg_address_out), 32'h0000);
        chk("rst_data", 32'(prg_data_out), 32'h00);
        chk("rst_done", 32'(done_out), 32'd0);
        reset_in = 1'b0;
        repeat (30) @(negedge cart_clk_in);

        // Load 5'b01010 into prg at 12:1.
        base = wr_addr.size(); hbase = highs.size(); d0 = done_cnt;
        issue(2'd3, 5'b01010, 1'b0, 1'b0);
        wait_done(d0 + 1, "load_done");
        repeat (3) @(negedge cart_clk_in);
        chk("load_nwrites", 32'(wr_addr.size() - base), 32'd5);
        v = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            chk("load_addr", 32'(wr_addr[base + i]), 32'hE000);
            chk("load_bit", 32'(wr_data[base + i]), 32'(v[i]));
        end
        chk("load_prg", 32'(map_reg[3]), 32'h0A);
        chk("load_latency", 32'(done_frame - first_frame), 32'd9);
        chk("load_one_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_addr", 32'(prg_address_out), 32'h0000);
        chk("idle_data", 32'(prg_data_out), 32'h00);
        for (int i = hbase; i < highs.size(); i++) chk("load_high", 32'(highs[i]), 32'd12);

        // Shift-register reset request.
        base = wr_addr.size(); d0 = done_cnt;
        issue(2'd2, 5'h1F, 1'b1, 1'b0);
        wait_done(d0 + 1, "rreq_done");
        repeat (3) @(negedge cart_clk_in);
        chk("rreq_nwrites", 32'(wr_addr.size() - base), 32'd1);
        chk("rreq_addr", 32'(wr_addr[base]), 32'h8000);
        chk("rreq_data", 32'(wr_data[base]), 32'h80);
        chk("rreq_latency", 32'(done_frame - first_frame), 32'd1);
        chk("rreq_mapcnt", 32'(map_cnt), 32'd0);

        // Back-to-back with valid held high.
        gbase = gaps.size(); d0 = done_cnt;
        issue(2'd0, 5'h0C, 1'b0, 1'b1);
        issue(2'd1, 5'h13, 1'b0, 1'b0);
        wait_done(d0 + 2, "b2b_done");
        repeat (3) @(negedge cart_clk_in);
        chk("b2b_control", 32'(map_reg[0]), 32'h0C);
        chk("b2b_chr0", 32'(map_reg[1]), 32'h13);
        min_gap = 1 << 30;
        for (int i = gbase; i < gaps.size(); i++) if (gaps[i] < min_gap) min_gap = gaps[i];
        chk("b2b_min_gap", 32'(min_gap >= 12), 32'd1);

        // Abort a load after its second bit.
        base = wr_addr.size(); d0 = done_cnt;
        issue(2'd3, 5'h15, 1'b0, 1'b0);
        n = 0;
        while (!(wr_addr.size() >= base + 2 && !prg_write_out) && n < 2000) begin
            @(negedge cart_clk_in);
            n++;
        end
        chk("abort_two_writes", 32'(wr_addr.size() - base), 32'd2);
        reset_in = 1'b1;
        repeat (2) @(negedge cart_clk_in);
        reset_in = 1'b0;
        repeat (60) @(negedge cart_clk_in);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_partial", 32'(map_cnt), 32'd2);
        chk("abort_ready", 32'(req_ready_out), 32'd1);
        chk("abort_nwrites", 32'(wr_addr.size() - base), 32'd2);
        issue(2'd0, 5'd0, 1'b1, 1'b0);
        wait_done(d0 + 1, "abort_rreq_done");
        repeat (3) @(negedge cart_clk_in);
        chk("abort_mapcnt", 32'(map_cnt), 32'd0);
        issue(2'd3, 5'h07, 1'b0, 1'b0);
        wait_done(d0 + 2, "abort_reload_done");
        repeat (3) @(negedge cart_clk_in);
        chk("abort_prg", 32'(map_reg[3]), 32'h07);

        // 2:1 ratio, acceptance on a cpu_frame cycle.
        half_ratio = 1;
        repeat (20) @(negedge cart_clk_in);
        n = 0;
        do begin
            @(negedge cart_clk_in);
            #1;
            n++;
        end while (!(cpu_clk_in && !cpu_last_tb) && n < 100);
        base = wr_addr.size(); hbase = highs.size(); gbase = gaps.size(); d0 = done_cnt;
        req_reg_in = 2'd3;
        req_data_in = 5'b10110;
        req_reset_in = 1'b0;
        req_valid_in = 1'b1;
        @(posedge cart_clk_in);
        #2;
        accept_frame = frames_total;
        chk("r2_accepted", 32'(req_ready_out), 32'd0);
        @(negedge cart_clk_in);
        req_valid_in = 1'b0;
        wait_done(d0 + 1, "r2_done");
        repeat (3) @(negedge cart_clk_in);
        chk("r2_nwrites", 32'(wr_addr.size() - base), 32'd5);
        v = 5'b10110;
        for (int i = 0; i < 5; i++) chk("r2_bit", 32'(wr_data[base + i]), 32'(v[i]));
        chk("r2_arm_wait", 32'(first_frame - accept_frame), 32'd1);
        chk("r2_latency", 32'(done_frame - first_frame), 32'd9);
        for (int i = hbase; i < highs.size(); i++) chk("r2_high", 32'(highs[i]), 32'd2);
        min_gap = 1 << 30;
        for (int i = gbase; i < gaps.size(); i++) if (gaps[i] < min_gap) min_gap = gaps[i];
        chk("r2_min_gap", 32'(min_gap >= 2), 32'd1);
        chk("r2_prg", 32'(map_reg[3]), 32'h16);

        // Inputs toggled while busy must not disturb the latched request.
        base = wr_addr.size(); d0 = done_cnt;
        issue(2'd1, 5'h11, 1'b0, 1'b0);
        n = 0;
        while (n < 200) begin
            @(negedge cart_clk_in);
            if (done_cnt > d0) break;
            chk("busy_ready", 32'(req_ready_out), 32'd0);
            req_data_in = ~req_data_in;
            req_reg_in = req_reg_in + 2'd1;
            n++;
        end
        wait_done(d0 + 1, "hs_done");
        repeat (3) @(negedge cart_clk_in);
        chk("hs_chr0", 32'(map_reg[1]), 32'h11);
        chk("hs_addr", 32'(wr_addr[base]), 32'hA000);
        chk("hs_nwrites", 32'(wr_addr.size() - base), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
